jtpopeye_romarb: RTL and testbench

- Read-only arbiter that shares one 32-bit SDRAM read port between three ROM clients: object ROM, background ROM and main CPU ROM.
- Each client has a one-entry word cache and an address-compare "ok" flag, so repeated reads of the same word need no SDRAM access.
- Sits between the video/CPU blocks and the SDRAM controller.
- Fixed priority: object, then background, then CPU. Video fetches are bounded by pixel timing, so CPU starvation is bounded.

---
 rtl/jtpopeye_romarb.sv | 110 +++++++++++
 tb/tb_jtpopeye_romarb.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/jtpopeye_romarb.sv
// jtpopeye_romarb: shares one SDRAM read port between object, background and CPU ROM clients,
// each fronted by a one-word cache, with fixed priority obj > bg > cpu.
module jtpopeye_romarb #(
  parameter logic [21:0] OBJ_OFFSET = 22'h00_0000,
  parameter logic [21:0] BG_OFFSET  = 22'h00_2000,
  parameter logic [21:0] CPU_OFFSET = 22'h00_4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        obj_cs,
  input  logic [12:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  input  logic        bg_cs,
  input  logic [12:0] bg_addr,
  output logic [31:0] bg_data,
  output logic        bg_ok,
  input  logic        cpu_cs,
  input  logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data,
  output logic        cpu_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [31:0] sdram_data
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DST} state_t;
  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [12:0]       iss_q, iss_d;
  logic              req_q, req_d;
  logic [21:0]       saddr_q, saddr_d;
  logic [2:0]        val_q;
  logic [2:0][12:0]  tag_q;
  logic [2:0][31:0]  dat_q;
  logic [2:0][12:0]  waddr;
  logic [2:0][21:0]  offs;
  logic [2:0]        cs, hit, pend;
  logic              wr;
  logic [31:0]       cpu_word;
  // client index 0 = obj, 1 = bg, 2 = cpu
  assign waddr = {cpu_addr[14:2], bg_addr, obj_addr};
  assign offs  = {CPU_OFFSET, BG_OFFSET, OBJ_OFFSET};
  assign cs    = {cpu_cs, bg_cs, obj_cs};
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) hit[i] = val_q[i] && tag_q[i] == waddr[i];
  end
  assign pend       = cs & ~hit;
  assign obj_ok     = obj_cs & hit[0];
  assign bg_ok      = bg_cs & hit[1];
  assign cpu_ok     = cpu_cs & hit[2];
  assign obj_data   = dat_q[0];
  assign bg_data    = dat_q[1];
  assign cpu_word   = dat_q[2];
  assign cpu_data   = cpu_word[{cpu_addr[1:0], 3'b000} +: 8];
  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    iss_d   = iss_q;
    req_d   = req_q;
    saddr_d = saddr_q;
    wr      = 1'b0;
    case (state_q)
      IDLE: if (|pend) begin
        sel_d   = pend[0] ? 2'd0 : pend[1] ? 2'd1 : 2'd2;
        iss_d   = waddr[sel_d];
        req_d   = 1'b1;
        saddr_d = offs[sel_d] + {9'd0, iss_d};
        state_d = WAIT_ACK;
      end
      WAIT_ACK: if (sdram_ack) begin
        req_d   = 1'b0;
        wr      = sdram_dst;
        state_d = sdram_dst ? IDLE : WAIT_DST;
      end
      WAIT_DST: if (sdram_dst) begin
        wr      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      iss_q   <= '0;
      req_q   <= 1'b0;
      saddr_q <= '0;
      val_q   <= '0;
      tag_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      iss_q   <= iss_d;
      req_q   <= req_d;
      saddr_q <= saddr_d;
      if (wr) begin
        val_q[sel_q] <= 1'b1;
        tag_q[sel_q] <= iss_q;
        dat_q[sel_q] <= sdram_data;
      end
    end
  end
endmodule

// File: tb/tb_jtpopeye_romarb.sv
// tb_jtpopeye_romarb: directed per-cycle vectors for the ROM arbiter plus a hand-written
// reset-during-transaction sequence.
module tb_jtpopeye_romarb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        obj_cs = 1'b0, bg_cs = 1'b0, cpu_cs = 1'b0;
  logic [12:0] obj_addr = '0, bg_addr = '0;
  logic [14:0] cpu_addr = '0;
  logic [31:0] obj_data, bg_data;
  logic [7:0]  cpu_data;
  logic        obj_ok, bg_ok, cpu_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0, sdram_dst = 1'b0;
  logic [31:0] sdram_data = '0;
  int          checks = 0, errors = 0;

  jtpopeye_romarb dut (
    .clk(clk), .rst_n(rst_n),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .bg_cs(bg_cs), .bg_addr(bg_addr), .bg_data(bg_data), .bg_ok(bg_ok),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_data(sdram_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic oc; logic [12:0] oa; logic bc; logic [12:0] ba; logic cc; logic [14:0] ca;
    logic ack; logic dst; logic [31:0] sd;
    logic req; logic [21:0] sa; logic ook; logic [31:0] od; logic bok; logic [31:0] bd;
    logic cok; logic [7:0] cd;
  } vec_t;

  vec_t v [30];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk_row(input string tag, input vec_t r);
    chk({tag, " sdram_req"}, 32'(sdram_req), 32'(r.req));
    chk({tag, " sdram_addr"}, 32'(sdram_addr), 32'(r.sa));
    chk({tag, " obj_ok"}, 32'(obj_ok), 32'(r.ook));
    chk({tag, " obj_data"}, obj_data, r.od);
    chk({tag, " bg_ok"}, 32'(bg_ok), 32'(r.bok));
    chk({tag, " bg_data"}, bg_data, r.bd);
    chk({tag, " cpu_ok"}, 32'(cpu_ok), 32'(r.cok));
    chk({tag, " cpu_data"}, 32'(cpu_data), 32'(r.cd));
  endtask

  initial begin
    //        oc oa       bc ba       cc ca        ack  dst  sd            req  sa          ook od            bok bd            cok cd
    v[0]  = '{1, 13'h10,  0, 13'h0,   0, 15'h0,    0,   0,   32'h0,        0,   22'h0,      0,  32'h0,        0,  32'h0,        0,  8'h00};
    v[1]  = '{1, 13'h10,  0, 13'h0,   0, 15'h0,    0,   0,   32'h0,        1,   22'h10,     0,  32'h0,        0,  32'h0,        0,  8'h00};
    v[2]  = '{1, 13'h10,  0, 13'h0,   0, 15'h0,    1,   0,   32'h0,        1,   22'h10,     0,  32'h0,        0,  32'h0,        0,  8'h00};
    v[3]  = '{1, 13'h10,  0, 13'h0,   0, 15'h0,    0,   0,   32'h0,        0,   22'h10,     0,  32'h0,        0,  32'h0,        0,  8'h00};
    v[4]  = '{1, 13'h10,  0, 13'h0,   0, 15'h0,    0,   1,   32'hDEADBEEF, 0,   22'h10,     0,  32'h0,        0,  32'h0,        0,  8'h00};
    v[5]  = '{1, 13'h10,  0, 13'h0,   0, 15'h0,    0,   0,   32'h0,        0,   22'h10,     1,  32'hDEADBEEF, 0,  32'h0,        0,  8'h00};
    v[6]  = '{1, 13'h10,  0, 13'h0,   0, 15'h0,    0,   0,   32'h0,        0,   22'h10,     1,  32'hDEADBEEF, 0,  32'h0,        0,  8'h00};
    v[7]  = '{1, 13'h11,  0, 13'h0,   0, 15'h0,    0,   0,   32'h0,        0,   22'h10,     0,  32'hDEADBEEF, 0,  32'h0,        0,  8'h00};
    v[8]  = '{1, 13'h11,  0, 13'h0,   0, 15'h0,    1,   1,   32'hCAFEF00D, 1,   22'h11,     0,  32'hDEADBEEF, 0,  32'h0,        0,  8'h00};
    v[9]  = '{1, 13'h11,  0, 13'h0,   0, 15'h0,    0,   0,   32'h0,        0,   22'h11,     1,  32'hCAFEF00D, 0,  32'h0,        0,  8'h00};
    v[10] = '{0, 13'h11,  0, 13'h0,   1, 15'h1235, 0,   0,   32'h0,        0,   22'h11,     0,  32'hCAFEF00D, 0,  32'h0,        0,  8'h00};
    v[11] = '{0, 13'h11,  0, 13'h0,   1, 15'h1235, 1,   0,   32'h0,        1,   22'h448D,   0,  32'hCAFEF00D, 0,  32'h0,        0,  8'h00};
    v[12] = '{0, 13'h11,  0, 13'h0,   1, 15'h1235, 0,   1,   32'h44332211, 0,   22'h448D,   0,  32'hCAFEF00D, 0,  32'h0,        0,  8'h00};
    v[13] = '{0, 13'h11,  0, 13'h0,   1, 15'h1235, 0,   0,   32'h0,        0,   22'h448D,   0,  32'hCAFEF00D, 0,  32'h0,        1,  8'h22};
    v[14] = '{0, 13'h11,  0, 13'h0,   1, 15'h1237, 0,   0,   32'h0,        0,   22'h448D,   0,  32'hCAFEF00D, 0,  32'h0,        1,  8'h44};
    v[15] = '{0, 13'h11,  0, 13'h0,   1, 15'h1237, 0,   0,   32'h0,        0,   22'h448D,   0,  32'hCAFEF00D, 0,  32'h0,        1,  8'h44};
    v[16] = '{1, 13'h20,  1, 13'h30,  1, 15'h0100, 0,   0,   32'h0,        0,   22'h448D,   0,  32'hCAFEF00D, 0,  32'h0,        0,  8'h11};
    v[17] = '{1, 13'h20,  1, 13'h30,  1, 15'h0100, 1,   1,   32'hA0A0A0A0, 1,   22'h000020, 0,  32'hCAFEF00D, 0,  32'h0,        0,  8'h11};
    v[18] = '{1, 13'h20,  1, 13'h30,  1, 15'h0100, 0,   0,   32'h0,        0,   22'h000020, 1,  32'hA0A0A0A0, 0,  32'h0,        0,  8'h11};
    v[19] = '{1, 13'h20,  1, 13'h30,  1, 15'h0100, 1,   0,   32'h0,        1,   22'h002030, 1,  32'hA0A0A0A0, 0,  32'h0,        0,  8'h11};
    v[20] = '{1, 13'h20,  1, 13'h30,  1, 15'h0100, 0,   1,   32'hB0B0B0B0, 0,   22'h002030, 1,  32'hA0A0A0A0, 0,  32'h0,        0,  8'h11};
    v[21] = '{1, 13'h20,  1, 13'h30,  1, 15'h0100, 0,   0,   32'h0,        0,   22'h002030, 1,  32'hA0A0A0A0, 1,  32'hB0B0B0B0, 0,  8'h11};
    v[22] = '{1, 13'h20,  1, 13'h30,  1, 15'h0100, 1,   1,   32'h0C0D0E0F, 1,   22'h004040, 1,  32'hA0A0A0A0, 1,  32'hB0B0B0B0, 0,  8'h11};
    v[23] = '{1, 13'h20,  1, 13'h30,  1, 15'h0100, 0,   0,   32'h0,        0,   22'h004040, 1,  32'hA0A0A0A0, 1,  32'hB0B0B0B0, 1,  8'h0F};
    v[24] = '{0, 13'h20,  1, 13'h100, 0, 15'h0100, 0,   0,   32'h0,        0,   22'h004040, 0,  32'hA0A0A0A0, 0,  32'hB0B0B0B0, 0,  8'h0F};
    v[25] = '{0, 13'h20,  1, 13'h100, 0, 15'h0100, 1,   0,   32'h0,        1,   22'h002100, 0,  32'hA0A0A0A0, 0,  32'hB0B0B0B0, 0,  8'h0F};
    v[26] = '{0, 13'h20,  1, 13'h200, 0, 15'h0100, 0,   1,   32'h12345678, 0,   22'h002100, 0,  32'hA0A0A0A0, 0,  32'hB0B0B0B0, 0,  8'h0F};
    v[27] = '{0, 13'h20,  1, 13'h200, 0, 15'h0100, 0,   0,   32'h0,        0,   22'h002100, 0,  32'hA0A0A0A0, 0,  32'h12345678, 0,  8'h0F};
    v[28] = '{0, 13'h20,  1, 13'h200, 0, 15'h0100, 1,   1,   32'h9ABCDEF0, 1,   22'h002200, 0,  32'hA0A0A0A0, 0,  32'h12345678, 0,  8'h0F};
    v[29] = '{0, 13'h20,  1, 13'h200, 0, 15'h0100, 0,   0,   32'h0,        0,   22'h002200, 0,  32'hA0A0A0A0, 1,  32'h9ABCDEF0, 0,  8'h0F};

    #2;
    chk("reset sdram_req", 32'(sdram_req), 32'h0);
    chk("reset sdram_addr", 32'(sdram_addr), 32'h0);
    chk("reset obj_data", obj_data, 32'h0);
    chk("reset ok flags", {29'd0, obj_ok, bg_ok, cpu_ok}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      obj_cs = v[i].oc; obj_addr = v[i].oa; bg_cs = v[i].bc; bg_addr = v[i].ba;
      cpu_cs = v[i].cc; cpu_addr = v[i].ca;
      sdram_ack = v[i].ack; sdram_dst = v[i].dst; sdram_data = v[i].sd;
      #2;
      chk_row($sformatf("vec%0d", i), v[i]);
      @(posedge clk); #1;
    end

    // reset while a request is outstanding, then a stray dst right after release
    obj_cs = 1'b1; obj_addr = 13'h50; bg_cs = 1'b1; bg_addr = 13'h200; cpu_cs = 1'b0;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = '0;
    #2;
    chk("rst_seq bg hit before reset", 32'(bg_ok), 32'h1);
    @(posedge clk); #1;
    chk("rst_seq req issued", 32'(sdram_req), 32'h1);
    chk("rst_seq addr issued", 32'(sdram_addr), 32'h50);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seq async req", 32'(sdram_req), 32'h0);
    chk("rst_seq async addr", 32'(sdram_addr), 32'h0);
    chk("rst_seq ok flags", {29'd0, obj_ok, bg_ok, cpu_ok}, 32'h0);
    chk("rst_seq bg_data", bg_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; sdram_dst = 1'b1; sdram_data = 32'hFFFFFFFF;
    #2;
    chk("rst_seq idle req", 32'(sdram_req), 32'h0);
    @(posedge clk); #1;
    sdram_dst = 1'b0; sdram_data = '0;
    #2;
    chk("rst_seq stray dst ignored", 32'(obj_ok), 32'h0);
    chk("rst_seq reissue req", 32'(sdram_req), 32'h1);
    chk("rst_seq reissue addr", 32'(sdram_addr), 32'h50);
    sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_data = 32'h55AA55AA;
    @(posedge clk); #1;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = '0;
    #2;
    chk("rst_seq obj_ok", 32'(obj_ok), 32'h1);
    chk("rst_seq obj_data", obj_data, 32'h55AA55AA);
    chk("rst_seq bg still missing", 32'(bg_ok), 32'h0);
    @(posedge clk); #1;
    chk("rst_seq bg reissue", 32'(sdram_addr), 32'h002200);
    chk("rst_seq bg req", 32'(sdram_req), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
